// File: rtl/axi_sram_write_slave.sv
// AXI4 write-channel slave that turns each W beat of a single outstanding AW burst into one SRAM write.
// Drives a word-addressed synchronous SRAM with active-low chip/byte enables and returns a single B response.
module axi_sram_write_slave #(
  parameter  int ID_W   = 8,
  parameter  int ADDR_W = 14,
  parameter  int DATA_W = 32,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [ID_W-1:0]   AWID,
  input  logic [31:0]       AWADDR,
  input  logic [3:0]        AWLEN,
  input  logic [2:0]        AWSIZE,
  input  logic [1:0]        AWBURST,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [DATA_W-1:0] WDATA,
  input  logic [STRB_W-1:0] WSTRB,
  input  logic              WLAST,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [ID_W-1:0]   BID,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  output logic              SRAM_CEB,
  output logic [STRB_W-1:0] SRAM_WEB,
  output logic [ADDR_W-1:0] SRAM_A,
  output logic [DATA_W-1:0] SRAM_DI
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WDATA,
    S_WRESP
  } state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     id_q,    id_d;
  logic [ADDR_W-1:0]   addr_q,  addr_d;
  logic [3:0]          len_q,   len_d;
  logic [1:0]          burst_q, burst_d;
  logic [3:0]          cnt_q,   cnt_d;
  logic                err_q,   err_d;
  logic                ill_q,   ill_d;

  logic                last_beat;
  logic                unused_awaddr;

  assign unused_awaddr = ^{AWADDR[31:ADDR_W+2], AWADDR[1:0]};
  assign last_beat     = (cnt_q == len_q);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= S_IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      burst_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ill_q   <= ill_d;
    end
  end

  // ill_q only suppresses SRAM writes; err_q also collects WLAST mismatches for BRESP.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    burst_d = burst_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ill_d   = ill_q;
    unique case (state_q)
      S_IDLE: begin
        if (AWVALID) begin
          state_d = S_WDATA;
          id_d    = AWID;
          addr_d  = AWADDR[ADDR_W+1:2];
          len_d   = AWLEN;
          burst_d = AWBURST;
          cnt_d   = '0;
          ill_d   = AWBURST[1] || (AWSIZE != 3'b010);
          err_d   = ill_d;
        end
      end
      S_WDATA: begin
        if (WVALID) begin
          cnt_d = cnt_q + 4'd1;
          if (burst_q == 2'b01) begin
            addr_d = addr_q + 1'b1;
          end
          if (WLAST != last_beat) begin
            err_d = 1'b1;
          end
          if (last_beat) begin
            state_d = S_WRESP;
          end
        end
      end
      S_WRESP: begin
        if (BREADY) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake readies come from state only; AWREADY is held low while reset is asserted.
  always_comb begin
    AWREADY  = 1'b0;
    WREADY   = 1'b0;
    BVALID   = 1'b0;
    SRAM_CEB = 1'b1;
    SRAM_WEB = '1;
    SRAM_DI  = '0;
    unique case (state_q)
      S_IDLE:  AWREADY = ARESETn;
      S_WDATA: begin
        WREADY = 1'b1;
        if (WVALID && !ill_q) begin
          SRAM_CEB = 1'b0;
          SRAM_WEB = ~WSTRB;
          SRAM_DI  = WDATA;
        end
      end
      S_WRESP: BVALID = 1'b1;
      default: ;
    endcase
  end

  assign SRAM_A = addr_q;
  assign BID    = id_q;
  assign BRESP  = err_q ? 2'b10 : 2'b00;

endmodule

// File: tb/tb_axi_sram_write_slave.sv
// Randomized bench for axi_sram_write_slave: expected SRAM writes and B responses come from a
// per-burst model of the AXI rules (address stepping, legality, WLAST agreement).
module tb_axi_sram_write_slave;
  localparam int ID_W   = 8;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  logic              ACLK = 1'b0;
  logic              ARESETn;
  logic [ID_W-1:0]   AWID;
  logic [31:0]       AWADDR;
  logic [3:0]        AWLEN;
  logic [2:0]        AWSIZE;
  logic [1:0]        AWBURST;
  logic              AWVALID;
  logic              AWREADY;
  logic [DATA_W-1:0] WDATA;
  logic [STRB_W-1:0] WSTRB;
  logic              WLAST;
  logic              WVALID;
  logic              WREADY;
  logic [ID_W-1:0]   BID;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;
  logic              SRAM_CEB;
  logic [STRB_W-1:0] SRAM_WEB;
  logic [ADDR_W-1:0] SRAM_A;
  logic [DATA_W-1:0] SRAM_DI;

  always #5 ACLK = ~ACLK;

  axi_sram_write_slave #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .SRAM_CEB(SRAM_CEB), .SRAM_WEB(SRAM_WEB), .SRAM_A(SRAM_A), .SRAM_DI(SRAM_DI)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned wr_cnt  = 0;

  logic [DATA_W-1:0] b_data [16];
  logic [STRB_W-1:0] b_strb [16];
  logic              b_last [16];
  int unsigned       b_gap  [16];

  always @(negedge ACLK) if (SRAM_CEB === 1'b0) wr_cnt <= wr_cnt + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_outs();
    check("rst_awready", AWREADY, 0);
    check("rst_wready", WREADY, 0);
    check("rst_bvalid", BVALID, 0);
    check("rst_bid", BID, 0);
    check("rst_bresp", BRESP, 0);
    check("rst_ceb", SRAM_CEB, 1);
    check("rst_web", SRAM_WEB, 4'hF);
    check("rst_a", SRAM_A, 0);
    check("rst_di", SRAM_DI, 0);
  endtask

  task automatic fill_beats(input int unsigned len);
    for (int i = 0; i < 16; i++) begin
      b_data[i] = $urandom;
      b_strb[i] = 4'($urandom);
      b_last[i] = (i == int'(len));
      b_gap[i]  = 0;
    end
  endtask

  task automatic run_burst(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input int unsigned bdelay, input bit pre_w);
    bit                legal, err, hs;
    int unsigned       n, w0;
    logic [ADDR_W-1:0] a;
    logic [STRB_W-1:0] web_e;
    legal = (burst[1] == 1'b0) && (size == 3'b010);
    err   = !legal;
    a     = addr[ADDR_W+1:2];
    w0    = wr_cnt;
    @(posedge ACLK); #1;
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    if (pre_w) begin
      WDATA = b_data[0]; WSTRB = b_strb[0]; WLAST = b_last[0]; WVALID = 1'b1;
    end
    n = 0;
    do begin
      @(negedge ACLK);
      hs = AWREADY;
      if (hs && pre_w) check("aw_with_w_no_write", SRAM_CEB, 1);
      @(posedge ACLK); #1;
      n++;
    end while (!hs && n < 64);
    check("aw_handshake", hs, 1);
    AWVALID = 1'b0; AWID = 8'($urandom); AWADDR = $urandom;
    for (int i = 0; i <= int'(len); i++) begin
      for (int g = 0; g < int'(b_gap[i]); g++) begin
        WVALID = 1'b0; WDATA = $urandom; WSTRB = 4'($urandom);
        @(negedge ACLK);
        check("gap_ceb", SRAM_CEB, 1);
        @(posedge ACLK); #1;
      end
      WDATA = b_data[i]; WSTRB = b_strb[i]; WLAST = b_last[i]; WVALID = 1'b1;
      @(negedge ACLK);
      check("wready", WREADY, 1);
      check("beat_ceb", SRAM_CEB, !legal);
      if (legal) begin
        web_e = ~b_strb[i];
        check("beat_web", SRAM_WEB, web_e);
        check("beat_addr", SRAM_A, a);
        check("beat_di", SRAM_DI, b_data[i]);
      end
      if (b_last[i] != (i == int'(len))) err = 1'b1;
      if (burst == 2'b01) a = a + 1'b1;
      @(posedge ACLK); #1;
    end
    WVALID = 1'b0;
    BREADY = (bdelay == 0);
    @(negedge ACLK);
    check("bvalid_latency", BVALID, 1);
    check("bid", BID, id);
    check("bresp", BRESP, err ? 2'b10 : 2'b00);
    check("b_awready", AWREADY, 0);
    check("write_count", wr_cnt - w0, legal ? int'(len) + 1 : 0);
    for (int d = 1; d <= int'(bdelay); d++) begin
      @(posedge ACLK); #1;
      AWVALID = 1'($urandom); WVALID = 1'($urandom); BREADY = (d == int'(bdelay));
      @(negedge ACLK);
      check("bvalid_hold", BVALID, 1);
      check("bid_hold", BID, id);
      check("bresp_hold", BRESP, err ? 2'b10 : 2'b00);
      check("hold_awready", AWREADY, 0);
      check("hold_wready", WREADY, 0);
      check("hold_ceb", SRAM_CEB, 1);
    end
    @(posedge ACLK); #1;
    BREADY = 1'b0; AWVALID = 1'b0; WVALID = 1'b0;
    @(negedge ACLK);
    check("awready_after_b", AWREADY, 1);
    check("bvalid_clear", BVALID, 0);
  endtask

  task automatic reset_mid_burst();
    int unsigned w0;
    fill_beats(3);
    @(posedge ACLK); #1;
    AWID = 8'h3C; AWADDR = 32'h200; AWLEN = 4'd3; AWSIZE = 3'b010; AWBURST = 2'b01; AWVALID = 1'b1;
    @(negedge ACLK);
    check("rm_awready", AWREADY, 1);
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    WDATA = b_data[0]; WSTRB = b_strb[0]; WLAST = 1'b0; WVALID = 1'b1;
    @(negedge ACLK);
    check("rm_beat0_ceb", SRAM_CEB, 0);
    check("rm_beat0_a", SRAM_A, 14'h080);
    @(posedge ACLK); #1;
    WDATA = b_data[1]; WSTRB = b_strb[1];
    #2 ARESETn = 1'b0;
    #1 check_reset_outs();
    w0 = wr_cnt;
    repeat (3) begin
      @(negedge ACLK);
      check("rm_reset_ceb", SRAM_CEB, 1);
    end
    @(posedge ACLK); #1;
    ARESETn = 1'b1; WVALID = 1'b0;
    @(negedge ACLK);
    check("rm_awready_release", AWREADY, 1);
    check("rm_wready_release", WREADY, 0);
    check("rm_no_writes", wr_cnt - w0, 0);
  endtask

  initial begin
    logic [1:0] bst;
    logic [2:0] sz;
    int unsigned r, len;
    ARESETn = 1'b0; AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = 3'b010; AWBURST = 2'b01;
    AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    repeat (3) @(posedge ACLK);
    #1 check_reset_outs();
    @(posedge ACLK); #1 ARESETn = 1'b1;
    @(negedge ACLK);
    check("awready_after_reset", AWREADY, 1);

    fill_beats(0);
    b_data[0] = 32'hDEADBEEF; b_strb[0] = 4'hF;
    run_burst(8'h15, 32'h10, 4'd0, 3'b010, 2'b01, 0, 1'b1);

    fill_beats(3);
    b_gap[1] = 1; b_gap[3] = 1;
    run_burst(8'h21, 32'h100, 4'd3, 3'b010, 2'b01, 0, 1'b0);

    fill_beats(2);
    for (int i = 0; i < 3; i++) b_strb[i] = 4'b0011;
    run_burst(8'h42, 32'h20, 4'd2, 3'b010, 2'b00, 1, 1'b0);

    fill_beats(1);
    run_burst(8'h77, 32'h400, 4'd1, 3'b010, 2'b01, 5, 1'b0);

    fill_beats(3);
    b_last[1] = 1'b1; b_last[3] = 1'b0;
    run_burst(8'h5A, 32'h300, 4'd3, 3'b010, 2'b01, 0, 1'b0);

    fill_beats(2);
    run_burst(8'hA5, 32'h340, 4'd2, 3'b010, 2'b11, 2, 1'b0);

    fill_beats(3);
    b_strb[2] = 4'h0;
    run_burst(8'h0F, 32'h0000_FFF8, 4'd3, 3'b010, 2'b01, 0, 1'b0);

    reset_mid_burst();
    fill_beats(3);
    run_burst(8'hC3, 32'h500, 4'd3, 3'b010, 2'b01, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      len = $urandom_range(0, 15);
      fill_beats(len);
      for (int i = 0; i <= int'(len); i++) begin
        b_gap[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
        if ($urandom_range(0, 15) == 0) b_last[i] = ~b_last[i];
      end
      r   = $urandom_range(0, 7);
      bst = (r < 3) ? 2'b00 : (r < 7) ? 2'b01 : {1'b1, 1'($urandom)};
      sz  = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b010;
      run_burst(8'($urandom), $urandom, 4'(len), sz, bst, $urandom_range(0, 3), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
